// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load-size encodings and FSM states.
package wb_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
  localparam logic [1:0] LS_FULL = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: selects a byte/half/word/full lane from raw
// memory data and sign- or zero-extends it to DATA_W.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BOFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [BOFF_W-1:0] off_i,
  output logic [DATA_W-1:0] data_o
);

  logic [BOFF_W-1:0] off_eff;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] mask;
  logic              top_bit;

  // Half and word accesses are naturally aligned, so low offset bits are dropped.
  always_comb begin
    off_eff = '0;
    case (size_i)
      LS_BYTE: off_eff = off_i;
      LS_HALF: off_eff = {off_i[BOFF_W-1:1], 1'b0};
      LS_WORD: off_eff = off_i & ~BOFF_W'(3);
      default: off_eff = '0;
    endcase
  end

  assign lane = data_i >> {off_eff, 3'b000};

  always_comb begin
    mask    = '1;
    top_bit = lane[DATA_W-1];
    case (size_i)
      LS_BYTE: begin
        mask    = DATA_W'(8'hFF);
        top_bit = lane[7];
      end
      LS_HALF: begin
        mask    = DATA_W'(16'hFFFF);
        top_bit = lane[15];
      end
      LS_WORD: begin
        mask    = DATA_W'(32'hFFFF_FFFF);
        top_bit = lane[31];
      end
      default: begin
        mask    = '1;
        top_bit = lane[DATA_W-1];
      end
    endcase
  end

  assign data_o = (lane & mask) | ((signed_i && top_bit) ? ~mask : '0);

endmodule

// File: rtl/write_back_stage.sv
// Registered write-back stage: selects load/EXU/return-link data, stalls for
// late memory data with a timeout, and exposes a same-cycle forwarding port.
module write_back_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int RET_OFFSET = 1,
  parameter int WAIT_MAX   = 15,
  parameter int BOFF_W     = $clog2(DATA_W / 8)
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iExuData,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemReady,
  input  logic              iMemToReg,
  input  logic              iRetCmd,
  input  logic              iRegWrite,
  input  logic [REG_W-1:0]  iDestReg,
  input  logic [1:0]        iLoadSize,
  input  logic              iLoadSigned,
  input  logic [BOFF_W-1:0] iByteOff,
  output logic [DATA_W-1:0] oWriteData,
  output logic [REG_W-1:0]  oWriteReg,
  output logic              oWriteEn,
  output logic [DATA_W-1:0] oFwdData,
  output logic [REG_W-1:0]  oFwdReg,
  output logic              oFwdValid,
  output logic              oBusy,
  output logic              oMemTimeout
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  // Handshake: an instruction is accepted when iValid=1 and oBusy=0; while
  // oBusy=1 upstream must hold and iValid is ignored. iMemReady qualifies
  // iMemData only for the load being accepted (IDLE) or the held load (WAIT_MEM).
  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_W-1:0]  h_dest_q, h_dest_d;
  logic              h_we_q, h_we_d;
  logic [1:0]        h_size_q, h_size_d;
  logic              h_signed_q, h_signed_d;
  logic [BOFF_W-1:0] h_off_q, h_off_d;
  logic              busy_d, tmo_d;

  logic [1:0]        al_size;
  logic              al_signed;
  logic [BOFF_W-1:0] al_off;
  logic [DATA_W-1:0] al_data;
  logic [DATA_W-1:0] exu_val;

  assign al_size   = (state_q == WAIT_MEM) ? h_size_q   : iLoadSize;
  assign al_signed = (state_q == WAIT_MEM) ? h_signed_q : iLoadSigned;
  assign al_off    = (state_q == WAIT_MEM) ? h_off_q    : iByteOff;

  load_align #(
    .DATA_W (DATA_W),
    .BOFF_W (BOFF_W)
  ) u_load_align (
    .data_i   (iMemData),
    .size_i   (al_size),
    .signed_i (al_signed),
    .off_i    (al_off),
    .data_o   (al_data)
  );

  assign exu_val = iRetCmd ? (iExuData + DATA_W'(RET_OFFSET)) : iExuData;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    h_dest_d   = h_dest_q;
    h_we_d     = h_we_q;
    h_size_d   = h_size_q;
    h_signed_d = h_signed_q;
    h_off_d    = h_off_q;
    busy_d     = 1'b0;
    tmo_d      = 1'b0;
    oFwdValid  = 1'b0;
    oFwdData   = exu_val;
    oFwdReg    = iDestReg;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          if (!iMemToReg) begin
            oFwdValid = iRegWrite && (iDestReg != '0);
          end else if (iMemReady) begin
            oFwdData  = al_data;
            oFwdValid = iRegWrite && (iDestReg != '0);
          end else begin
            h_dest_d   = iDestReg;
            h_we_d     = iRegWrite;
            h_size_d   = iLoadSize;
            h_signed_d = iLoadSigned;
            h_off_d    = iByteOff;
            cnt_d      = '0;
            busy_d     = 1'b1;
            state_d    = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        oFwdData = al_data;
        oFwdReg  = h_dest_q;
        // A late iMemReady on the final wait cycle still completes the load.
        if (iMemReady) begin
          oFwdValid = h_we_q && (h_dest_q != '0);
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      h_dest_q    <= '0;
      h_we_q      <= 1'b0;
      h_size_q    <= LS_BYTE;
      h_signed_q  <= 1'b0;
      h_off_q     <= '0;
      oWriteData  <= '0;
      oWriteReg   <= '0;
      oWriteEn    <= 1'b0;
      oBusy       <= 1'b0;
      oMemTimeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      h_dest_q    <= h_dest_d;
      h_we_q      <= h_we_d;
      h_size_q    <= h_size_d;
      h_signed_q  <= h_signed_d;
      h_off_q     <= h_off_d;
      oWriteData  <= oFwdData;
      oWriteReg   <= oFwdReg;
      oWriteEn    <= oFwdValid;
      oBusy       <= busy_d;
      oMemTimeout <= tmo_d;
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_write_back_stage;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int WAIT_MAX = 15;
  localparam int BOFF_W   = 2;
  localparam int EXP_W    = 1 + REG_W + DATA_W + 1 + 1;

  logic              iClk = 1'b0;
  logic              iRst_n;
  logic              iValid;
  logic [DATA_W-1:0] iExuData;
  logic [DATA_W-1:0] iMemData;
  logic              iMemReady;
  logic              iMemToReg;
  logic              iRetCmd;
  logic              iRegWrite;
  logic [REG_W-1:0]  iDestReg;
  logic [1:0]        iLoadSize;
  logic              iLoadSigned;
  logic [BOFF_W-1:0] iByteOff;
  logic [DATA_W-1:0] oWriteData;
  logic [REG_W-1:0]  oWriteReg;
  logic              oWriteEn;
  logic [DATA_W-1:0] oFwdData;
  logic [REG_W-1:0]  oFwdReg;
  logic              oFwdValid;
  logic              oBusy;
  logic              oMemTimeout;

  int n_checks = 0;
  int n_errors = 0;

  logic [EXP_W-1:0] exp_q[$];

  write_back_stage #(
    .DATA_W     (DATA_W),
    .REG_W      (REG_W),
    .RET_OFFSET (1),
    .WAIT_MAX   (WAIT_MAX)
  ) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iValid      (iValid),
    .iExuData    (iExuData),
    .iMemData    (iMemData),
    .iMemReady   (iMemReady),
    .iMemToReg   (iMemToReg),
    .iRetCmd     (iRetCmd),
    .iRegWrite   (iRegWrite),
    .iDestReg    (iDestReg),
    .iLoadSize   (iLoadSize),
    .iLoadSigned (iLoadSigned),
    .iByteOff    (iByteOff),
    .oWriteData  (oWriteData),
    .oWriteReg   (oWriteReg),
    .oWriteEn    (oWriteEn),
    .oFwdData    (oFwdData),
    .oFwdReg     (oFwdReg),
    .oFwdValid   (oFwdValid),
    .oBusy       (oBusy),
    .oMemTimeout (oMemTimeout)
  );

  // Clock / reset
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Drivers
  task automatic drive_idle();
    iValid      = 1'b0;
    iExuData    = '0;
    iMemData    = '0;
    iMemReady   = 1'b0;
    iMemToReg   = 1'b0;
    iRetCmd     = 1'b0;
    iRegWrite   = 1'b0;
    iDestReg    = '0;
    iLoadSize   = 2'b00;
    iLoadSigned = 1'b0;
    iByteOff    = '0;
  endtask

  task automatic drive_exu(input logic [DATA_W-1:0] d, input logic ret,
                           input logic [REG_W-1:0] r);
    drive_idle();
    iValid    = 1'b1;
    iExuData  = d;
    iRetCmd   = ret;
    iRegWrite = 1'b1;
    iDestReg  = r;
  endtask

  task automatic drive_load(input logic [DATA_W-1:0] md, input logic rdy,
                            input logic [1:0] sz, input logic sg,
                            input logic [BOFF_W-1:0] off, input logic [REG_W-1:0] r);
    drive_idle();
    iValid      = 1'b1;
    iMemToReg   = 1'b1;
    iMemData    = md;
    iMemReady   = rdy;
    iRegWrite   = 1'b1;
    iDestReg    = r;
    iLoadSize   = sz;
    iLoadSigned = sg;
    iByteOff    = off;
  endtask

  // Reference load extraction, computed with plain shift/modulo arithmetic.
  function automatic logic [DATA_W-1:0] ref_load(input logic [DATA_W-1:0] d,
      input logic [1:0] sz, input logic sg, input logic [BOFF_W-1:0] off);
    int bits;
    int byte_pos;
    logic [63:0] v;
    case (sz)
      2'b00:   begin bits = 8;  byte_pos = int'(off); end
      2'b01:   begin bits = 16; byte_pos = (int'(off) / 2) * 2; end
      2'b10:   begin bits = 32; byte_pos = (int'(off) / 4) * 4; end
      default: begin bits = DATA_W; byte_pos = 0; end
    endcase
    v = (64'(d) >> (8 * byte_pos)) % (64'd1 << bits);
    if (sg && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[DATA_W-1:0];
  endfunction

  task automatic test_reset();
    drive_idle();
    iRst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (oWriteEn !== 1'b0) begin
      n_errors++; $display("FAIL reset_we: got %b expected 0", oWriteEn);
    end
    n_checks++;
    if (oWriteData !== '0) begin
      n_errors++; $display("FAIL reset_data: got %h expected 0", oWriteData);
    end
    n_checks++;
    if (oWriteReg !== '0) begin
      n_errors++; $display("FAIL reset_reg: got %h expected 0", oWriteReg);
    end
    n_checks++;
    if ({oBusy, oMemTimeout} !== 2'b00) begin
      n_errors++; $display("FAIL reset_busy_tmo: got %b expected 00", {oBusy, oMemTimeout});
    end
    iRst_n = 1'b1;
    tick();
  endtask

  task automatic test_exu();
    drive_exu(32'h0000_1234, 1'b0, 5'd3);
    #3;
    n_checks++;
    if ({oFwdValid, oFwdReg, oFwdData} !== {1'b1, 5'd3, 32'h0000_1234}) begin
      n_errors++;
      $display("FAIL exu_fwd: got v=%b r=%0d d=%h expected v=1 r=3 d=00001234",
               oFwdValid, oFwdReg, oFwdData);
    end
    tick();
    drive_idle();
    n_checks++;
    if ({oWriteEn, oWriteReg, oWriteData} !== {1'b1, 5'd3, 32'h0000_1234}) begin
      n_errors++;
      $display("FAIL exu_write: got en=%b r=%0d d=%h expected en=1 r=3 d=00001234",
               oWriteEn, oWriteReg, oWriteData);
    end
    tick();
    n_checks++;
    if (oWriteEn !== 1'b0) begin
      n_errors++; $display("FAIL exu_pulse: got en=%b expected 0", oWriteEn);
    end
  endtask

  task automatic test_ret_wrap();
    drive_exu(32'hFFFF_FFFF, 1'b1, 5'd31);
    tick();
    n_checks++;
    if ({oWriteEn, oWriteReg, oWriteData} !== {1'b1, 5'd31, 32'h0000_0000}) begin
      n_errors++;
      $display("FAIL ret_wrap: got en=%b r=%0d d=%h expected en=1 r=31 d=00000000",
               oWriteEn, oWriteReg, oWriteData);
    end
    drive_load(32'h80F1_7F82, 1'b1, 2'b10, 1'b0, 2'd0, 5'd31);
    iRetCmd  = 1'b1;
    iExuData = 32'h0000_0010;
    tick();
    drive_idle();
    n_checks++;
    if ({oWriteEn, oWriteData} !== {1'b1, 32'h80F1_7F82}) begin
      n_errors++;
      $display("FAIL ret_vs_mem: got en=%b d=%h expected en=1 d=80f17f82", oWriteEn, oWriteData);
    end
  endtask

  task automatic test_load_extract();
    logic [1:0]        sz_t[6]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic              sg_t[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [BOFF_W-1:0] off_t[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [DATA_W-1:0] exp_t[6] = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1,
                                   32'hFFFF_80F1, 32'h80F1_7F82, 32'h80F1_7F82};
    for (int i = 0; i < 6; i++) begin
      drive_load(32'h80F1_7F82, 1'b1, sz_t[i], sg_t[i], off_t[i], 5'd4);
      #3;
      n_checks++;
      if ({oFwdValid, oFwdData} !== {1'b1, exp_t[i]}) begin
        n_errors++;
        $display("FAIL load_fwd[%0d]: got v=%b d=%h expected v=1 d=%h",
                 i, oFwdValid, oFwdData, exp_t[i]);
      end
      tick();
      n_checks++;
      if ({oWriteEn, oWriteReg, oWriteData} !== {1'b1, 5'd4, exp_t[i]}) begin
        n_errors++;
        $display("FAIL load_write[%0d]: got en=%b r=%0d d=%h expected en=1 r=4 d=%h",
                 i, oWriteEn, oWriteReg, oWriteData, exp_t[i]);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_late_mem();
    int busy_cycles = 0;
    int writes = 0;
    drive_load(32'h0000_5500, 1'b0, 2'b00, 1'b0, 2'd1, 5'd7);
    tick();
    for (int i = 0; i < 3; i++) begin
      // Intruding instruction with different load controls must be ignored.
      drive_exu(32'hDEAD_BEEF, 1'b0, 5'd9);
      iLoadSize = 2'b11;
      iByteOff  = 2'd0;
      if (oBusy === 1'b1) busy_cycles++;
      if (oWriteEn === 1'b1) writes++;
      #3;
      n_checks++;
      if (oFwdValid !== 1'b0) begin
        n_errors++; $display("FAIL late_ignore[%0d]: got fwd_v=%b expected 0", i, oFwdValid);
      end
      tick();
    end
    drive_idle();
    iMemReady = 1'b1;
    iMemData  = 32'h0000_5500;
    iLoadSize = 2'b11;
    if (oBusy === 1'b1) busy_cycles++;
    if (oWriteEn === 1'b1) writes++;
    #3;
    n_checks++;
    if ({oFwdValid, oFwdReg, oFwdData} !== {1'b1, 5'd7, 32'h0000_0055}) begin
      n_errors++;
      $display("FAIL late_fwd: got v=%b r=%0d d=%h expected v=1 r=7 d=00000055",
               oFwdValid, oFwdReg, oFwdData);
    end
    tick();
    drive_idle();
    n_checks++;
    if ({oBusy, oWriteEn, oWriteReg, oWriteData} !== {1'b0, 1'b1, 5'd7, 32'h0000_0055}) begin
      n_errors++;
      $display("FAIL late_write: got busy=%b en=%b r=%0d d=%h expected busy=0 en=1 r=7 d=00000055",
               oBusy, oWriteEn, oWriteReg, oWriteData);
    end
    tick();
    if (oWriteEn === 1'b1) writes++;
    n_checks++;
    if (busy_cycles != 4 || writes != 0) begin
      n_errors++;
      $display("FAIL late_busy_count: got busy=%0d extra_writes=%0d expected busy=4 extra_writes=0",
               busy_cycles, writes);
    end
  endtask

  task automatic test_timeout();
    int tmo_at = -1;
    int tmo_cnt = 0;
    int busy_cnt = 0;
    int writes = 0;
    drive_load(32'h1234_5678, 1'b0, 2'b10, 1'b0, 2'd0, 5'd12);
    tick();
    drive_idle();
    for (int t = 1; t <= 25; t++) begin
      if (oMemTimeout === 1'b1) begin
        tmo_cnt++;
        if (tmo_at < 0) tmo_at = t;
      end
      if (oBusy === 1'b1) busy_cnt++;
      if (oWriteEn === 1'b1) writes++;
      tick();
    end
    n_checks++;
    if (tmo_at != WAIT_MAX + 1 || tmo_cnt != 1) begin
      n_errors++;
      $display("FAIL timeout_pulse: got at=%0d count=%0d expected at=%0d count=1",
               tmo_at, tmo_cnt, WAIT_MAX + 1);
    end
    n_checks++;
    if (busy_cnt != WAIT_MAX || writes != 0) begin
      n_errors++;
      $display("FAIL timeout_busy: got busy=%0d writes=%0d expected busy=%0d writes=0",
               busy_cnt, writes, WAIT_MAX);
    end
  endtask

  task automatic test_timeout_edge_ready();
    // Ready arriving on the last permitted wait cycle completes the load.
    drive_load(32'h0000_00A5, 1'b0, 2'b00, 1'b1, 2'd0, 5'd13);
    tick();
    drive_idle();
    for (int t = 0; t < WAIT_MAX - 1; t++) tick();
    iMemReady = 1'b1;
    iMemData  = 32'h0000_00A5;
    tick();
    drive_idle();
    n_checks++;
    if ({oMemTimeout, oWriteEn, oWriteData} !== {1'b0, 1'b1, 32'hFFFF_FFA5}) begin
      n_errors++;
      $display("FAIL timeout_edge: got tmo=%b en=%b d=%h expected tmo=0 en=1 d=ffffffa5",
               oMemTimeout, oWriteEn, oWriteData);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int writes = 0;
    drive_load(32'h0, 1'b0, 2'b00, 1'b0, 2'd0, 5'd5);
    tick();
    drive_idle();
    tick();
    iRst_n = 1'b0;
    tick();
    n_checks++;
    if ({oBusy, oWriteEn, oMemTimeout, oWriteReg, oWriteData} !== '0) begin
      n_errors++;
      $display("FAIL rst_wait_outputs: got busy=%b en=%b tmo=%b r=%0d d=%h expected all 0",
               oBusy, oWriteEn, oMemTimeout, oWriteReg, oWriteData);
    end
    iRst_n    = 1'b1;
    iMemReady = 1'b1;
    iMemData  = 32'h0000_0077;
    #3;
    n_checks++;
    if (oFwdValid !== 1'b0) begin
      n_errors++; $display("FAIL rst_wait_fwd: got %b expected 0", oFwdValid);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      if (oWriteEn === 1'b1) writes++;
    end
    drive_idle();
    n_checks++;
    if (writes != 0) begin
      n_errors++; $display("FAIL rst_wait_write: got %0d writes expected 0", writes);
    end
  endtask

  task automatic test_r0();
    drive_exu(32'hCAFE_0001, 1'b0, 5'd0);
    #3;
    n_checks++;
    if (oFwdValid !== 1'b0) begin
      n_errors++; $display("FAIL r0_fwd: got %b expected 0", oFwdValid);
    end
    tick();
    drive_load(32'h1, 1'b1, 2'b10, 1'b0, 2'd0, 5'd0);
    n_checks++;
    if (oWriteEn !== 1'b0) begin
      n_errors++; $display("FAIL r0_exu_we: got %b expected 0", oWriteEn);
    end
    tick();
    drive_idle();
    n_checks++;
    if (oWriteEn !== 1'b0) begin
      n_errors++; $display("FAIL r0_load_we: got %b expected 0", oWriteEn);
    end
    tick();
  endtask

  // Randomized run against a transaction-level model: an outstanding load
  // either completes when data arrives or gives up after WAIT_MAX idle cycles.
  task automatic test_random();
    logic              pend = 1'b0;
    int                waited = 0;
    logic [REG_W-1:0]  s_dst = '0;
    logic              s_we = 1'b0;
    logic [1:0]        s_sz = '0;
    logic              s_sg = 1'b0;
    logic [BOFF_W-1:0] s_off = '0;
    logic              e_en, e_tmo;
    logic [REG_W-1:0]  e_reg;
    logic [DATA_W-1:0] e_data;
    logic [EXP_W-1:0]  exp_v;
    for (int c = 0; c < 400; c++) begin
      drive_idle();
      iValid      = ($urandom_range(0, 3) != 0);
      iExuData    = $urandom;
      iMemData    = $urandom;
      iMemReady   = ($urandom_range(0, 3) == 0);
      iMemToReg   = $urandom_range(0, 1);
      iRetCmd     = $urandom_range(0, 1);
      iRegWrite   = ($urandom_range(0, 4) != 0);
      iDestReg    = $urandom_range(0, 31);
      iLoadSize   = $urandom_range(0, 3);
      iLoadSigned = $urandom_range(0, 1);
      iByteOff    = $urandom_range(0, 3);
      e_en = 1'b0; e_tmo = 1'b0; e_reg = '0; e_data = '0;
      if (!pend) begin
        if (iValid && !iMemToReg) begin
          e_en = iRegWrite && (iDestReg != 0); e_reg = iDestReg;
          e_data = iRetCmd ? iExuData + 32'd1 : iExuData;
        end else if (iValid && iMemReady) begin
          e_en = iRegWrite && (iDestReg != 0); e_reg = iDestReg;
          e_data = ref_load(iMemData, iLoadSize, iLoadSigned, iByteOff);
        end else if (iValid) begin
          pend = 1'b1; waited = 0; s_dst = iDestReg; s_we = iRegWrite;
          s_sz = iLoadSize; s_sg = iLoadSigned; s_off = iByteOff;
        end
      end else if (iMemReady) begin
        e_en = s_we && (s_dst != 0); e_reg = s_dst;
        e_data = ref_load(iMemData, s_sz, s_sg, s_off);
        pend = 1'b0;
      end else begin
        waited++;
        if (waited == WAIT_MAX) begin
          e_tmo = 1'b1; pend = 1'b0;
        end
      end
      exp_q.push_back({e_en, e_reg, e_data, pend, e_tmo});
      #3;
      n_checks++;
      if (oFwdValid !== e_en || (e_en && {oFwdReg, oFwdData} !== {e_reg, e_data})) begin
        n_errors++;
        $display("FAIL rand_fwd[%0d]: got v=%b r=%0d d=%h expected v=%b r=%0d d=%h",
                 c, oFwdValid, oFwdReg, oFwdData, e_en, e_reg, e_data);
      end
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (oWriteEn !== exp_v[EXP_W-1] || oBusy !== exp_v[1] || oMemTimeout !== exp_v[0] ||
          (exp_v[EXP_W-1] && {oWriteReg, oWriteData} !== exp_v[EXP_W-2:2])) begin
        n_errors++;
        $display("FAIL rand_out[%0d]: got en=%b r=%0d d=%h busy=%b tmo=%b expected en=%b r=%0d d=%h busy=%b tmo=%b",
                 c, oWriteEn, oWriteReg, oWriteData, oBusy, oMemTimeout,
                 exp_v[EXP_W-1], exp_v[EXP_W-2 -: REG_W], exp_v[DATA_W+1:2], exp_v[1], exp_v[0]);
      end
    end
    drive_idle();
    for (int t = 0; t < WAIT_MAX + 2; t++) tick();
  endtask

  initial begin
    drive_idle();
    iRst_n = 1'b0;
    test_reset();
    test_exu();
    test_ret_wrap();
    test_load_extract();
    test_late_mem();
    test_timeout();
    test_timeout_edge_ready();
    test_reset_in_wait();
    test_r0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Registered, parametrised write-back stage at the end of the CPU pipeline.
- Selects the register-file write value from three sources:
  - memory load data, with byte/half/word extraction and sign/zero extension;
  - the execution-unit result;
  - the return-link value, EXU result plus RET_OFFSET.
- Waits for late memory data with a stall handshake and timeout, and drives a same-cycle forwarding port toward the decode/execute hazard logic.

Parameters:
- DATA_W, 32: datapath width; must be a multiple of 32.
- REG_W, 5: register index width.
- RET_OFFSET, 1: constant added to EXU data for return commands.
- WAIT_MAX, 15: maximum cycles spent in WAIT_MEM before timeout.
- BOFF_W, $clog2(DATA_W/8): byte-offset width (derived; not overridden).

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst_n  in  1  synchronous active-low reset.
- iValid  in  1  instruction present this cycle.
- iExuData  in  DATA_W  execution-unit result.
- iMemData  in  DATA_W  raw memory read data.
- iMemReady  in  1  iMemData valid this cycle.
- iMemToReg  in  1  write value comes from memory.
- iRetCmd  in  1  write value is iExuData+RET_OFFSET (ignored when iMemToReg=1).
- iRegWrite  in  1  instruction writes the register file.
- iDestReg  in  REG_W  destination register index.
- iLoadSize  in  2  00 byte, 01 half, 10 word(32), 11 full DATA_W.
- iLoadSigned  in  1  sign-extend (1) or zero-extend (0).
- iByteOff  in  BOFF_W  byte offset of the load within iMemData.
- oWriteData  out  DATA_W  registered register-file write data.
- oWriteReg  out  REG_W  registered register-file write index.
- oWriteEn  out  1  registered register-file write enable.
- oFwdData  out  DATA_W  combinational value destined for oWriteData next edge.
- oFwdReg  out  REG_W  combinational destination for forwarding.
- oFwdValid  out  1  combinational: oFwdData/oFwdReg valid for bypass.
- oBusy  out  1  registered: stage waiting for memory data; upstream must hold.
- oMemTimeout  out  1  registered one-cycle pulse on memory timeout.

Behaviour:
- Reset (iRst_n=0 at an edge):
  - all registered outputs go to 0: oWriteData, oWriteReg, oWriteEn, oBusy, oMemTimeout;
  - FSM goes to IDLE and the wait counter to 0.
- Reset wins over every other event, including reset in WAIT_MEM: the pending load is dropped and no write is issued.
- Selection priority: iMemToReg > iRetCmd > EXU.
- Return value is iExuData+RET_OFFSET, truncated to DATA_W (wraps modulo 2^DATA_W).
- Load extraction: lane = iMemData >> (8*iByteOff).
  - byte: lane[7:0], extended to DATA_W;
  - half: uses iByteOff with bit0 forced to 0; lane[15:0] extended;
  - word: iByteOff low 2 bits forced to 0; lane[31:0] extended (no-op when DATA_W=32);
  - full: iByteOff ignored.
  - Extension is by the top bit of the field when iLoadSigned=1, zeros otherwise.
- Write enable is iRegWrite and iDestReg!=0; register 0 is never written.
- Latency: 1 cycle from accepted input (or iMemReady) to oWriteData/oWriteEn.
- oWriteEn is a single-cycle pulse per retired instruction.
- FSM states: IDLE and WAIT_MEM.
  - IDLE, iValid & !iMemToReg: write next edge.
  - IDLE, iValid & iMemToReg & iMemReady: aligned load written next edge, no stall.
  - IDLE, iValid & iMemToReg & !iMemReady:
    - capture iDestReg, iRegWrite, iLoadSize, iLoadSigned, iByteOff into hold registers;
    - oBusy=1 next edge; go to WAIT_MEM; counter=0.
  - WAIT_MEM, iMemReady:
    - align iMemData using the held controls; write next edge;
    - oBusy=0; go to IDLE.
  - WAIT_MEM, !iMemReady: counter+1.
  - WAIT_MEM, counter==WAIT_MAX-1 with !iMemReady:
    - oMemTimeout=1 for one cycle; no write; oBusy=0; go to IDLE.
  - iMemReady arriving in the same cycle as the timeout condition completes the load; there is no timeout.
- iValid while in WAIT_MEM is a protocol violation; the input is ignored and not captured.
- iMemReady in IDLE without iValid&iMemToReg is ignored.
- Forwarding: oFwdValid=1 exactly in the cycles whose next edge will assert oWriteEn; otherwise oFwdValid=0 and oFwdData/oFwdReg are don't-care.

Decomposition:
- Shared package wb_pkg:
  - load-size encodings LS_BYTE/LS_HALF/LS_WORD/LS_FULL;
  - FSM state enum (IDLE, WAIT_MEM).
- Sub-module load_align (combinational):
  - inputs: raw data, size, signed, byte offset;
  - output: extended DATA_W value;
  - reusable by the future store/LSU path.

Test Plan:
- EXU path: iValid=1, iExuData=0x0000_1234, iRegWrite=1, iDestReg=3 -> next cycle oWriteEn=1, oWriteReg=3, oWriteData=0x0000_1234; same-cycle oFwdValid=1, oFwdData=0x0000_1234.
- Return wrap: iRetCmd=1, iExuData=0xFFFF_FFFF, iDestReg=31 -> oWriteData=0x0000_0000; with iMemToReg=1 also set, memory path wins.
- Load extraction with iMemReady=1, iMemData=0x80F1_7F82:
  - byte signed off=0 -> 0xFFFF_FF82;
  - byte unsigned off=1 -> 0x0000_007F;
  - half signed off=2 -> 0xFFFF_80F1;
  - half off=3 -> same as off=2.
- Late memory: load issued with iMemReady=0 for 3 cycles, then iMemReady=1 with iMemData=0x55 (byte, unsigned):
  - oBusy=1 for 4 cycles, then 0;
  - a single oWriteEn pulse with 0x55 one cycle after iMemReady;
  - a new iValid during oBusy is ignored.
- Timeout and reset:
  - iMemReady held 0 -> oMemTimeout pulses once, WAIT_MAX cycles after entering WAIT_MEM; no oWriteEn.
  - Separate run: iRst_n=0 for one edge mid-WAIT_MEM -> all outputs 0 and no write when iMemReady later rises.
- R0 guard: iRegWrite=1, iDestReg=0 -> oWriteEn=0 and oFwdValid=0.
